// File: rtl/floo_route_select_multi.sv
// Per-channel NoC route selection with wormhole lock, optional pipe stage
// and sticky protocol error flags.
package floo_route_pkg;
    typedef enum logic [1:0] {
        XYRouting     = 2'd0,
        IdTable       = 2'd1,
        SourceRouting = 2'd2
    } route_algo_e;

    typedef struct packed {
        logic [5:0] dst_id;
        logic       last;
    } hdr_t;

    typedef struct packed {
        hdr_t       hdr;
        logic [7:0] payload;
    } flit_t;

    typedef struct packed {
        logic [2:0] idx;
        logic [5:0] start_addr;
        logic [5:0] end_addr;
    } id_rule_t;
endpackage

module floo_route_select_multi
    import floo_route_pkg::*;
#(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned NumRoutes    = 5,
    parameter route_algo_e RouteAlgo    = XYRouting,
    parameter int unsigned IdWidth      = 6,
    parameter int unsigned NumAddrRules = 4,
    parameter bit          LockRouting  = 1'b1,
    parameter bit          PipeReg      = 1'b0,
    parameter int unsigned MaxPktLen    = 16,
    parameter type         flit_t       = floo_route_pkg::flit_t,
    parameter type         rule_t       = floo_route_pkg::id_rule_t,
    localparam int unsigned RouteSelWidth = $clog2(NumRoutes)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [IdWidth-1:0]                         xy_id_i,
    input  rule_t [NumAddrRules-1:0]                   id_route_map_i,
    input  logic [NumChannels-1:0]                     valid_i,
    output logic [NumChannels-1:0]                     ready_o,
    input  flit_t [NumChannels-1:0]                    channel_i,
    output logic [NumChannels-1:0]                     valid_o,
    input  logic [NumChannels-1:0]                     ready_i,
    output flit_t [NumChannels-1:0]                    channel_o,
    output logic [NumChannels-1:0][NumRoutes-1:0]      route_sel_o,
    output logic [NumChannels-1:0][RouteSelWidth-1:0]  route_sel_id_o,
    input  logic                                       clear_err_i,
    output logic [NumChannels-1:0]                     err_mismatch_o,
    output logic [NumChannels-1:0]                     err_overlen_o,
    output logic [NumChannels-1:0]                     err_nomatch_o
);

    localparam int unsigned CntWidth = $clog2(MaxPktLen + 1);
    localparam int unsigned HalfW    = IdWidth / 2;

    typedef enum logic {Unlocked, Locked} lock_e;

    if (RouteAlgo != XYRouting && RouteAlgo != IdTable &&
        RouteAlgo != SourceRouting) begin : g_bad_algo
        $fatal(1, "unsupported RouteAlgo");
    end
    if (IdWidth % 2 != 0) begin : g_bad_idw
        $fatal(1, "IdWidth must be even");
    end
    if (MaxPktLen < 1) begin : g_bad_len
        $fatal(1, "MaxPktLen must be at least 1");
    end

    if (RouteAlgo != XYRouting) begin : g_xy_unused
        logic unused_xy;
        assign unused_xy = ^xy_id_i;
    end
    if (RouteAlgo != IdTable) begin : g_map_unused
        logic unused_map;
        assign unused_map = ^id_route_map_i;
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        flit_t                    in_flit, out_flit;
        logic [IdWidth-1:0]       dst;
        logic [RouteSelWidth-1:0] rid, sel_rid;
        logic [RouteSelWidth-1:0] lock_rid_q, lock_rid_d;
        lock_e                    state_q, state_d;
        logic [CntWidth-1:0]      cnt_q;
        logic                     hit, hs, last;
        logic                     set_mis, set_ovl, set_nom;
        logic [2:0]               err_q;

        assign in_flit = channel_i[c];
        assign dst     = in_flit.hdr.dst_id[IdWidth-1:0];
        assign last    = in_flit.hdr.last;
        assign hs      = valid_i[c] & ready_o[c];

        if (RouteAlgo == XYRouting) begin : g_xy
            logic [HalfW-1:0] x, y, my_x, my_y;
            assign {y, x}       = dst;
            assign {my_y, my_x} = xy_id_i;
            assign hit          = 1'b1;
            assign out_flit     = in_flit;
            always_comb begin
                rid = '0;
                if (x == my_x && y == my_y)
                    rid = RouteSelWidth'(0);
                else if (x == my_x)
                    rid = (y < my_y) ? RouteSelWidth'(1)
                                     : RouteSelWidth'(3);
                else
                    rid = (x < my_x) ? RouteSelWidth'(2)
                                     : RouteSelWidth'(4);
            end
        end else if (RouteAlgo == IdTable) begin : g_tab
            assign out_flit = in_flit;
            // Walk downwards so the lowest-indexed match wins.
            always_comb begin
                rid = '0;
                hit = 1'b0;
                for (int r = NumAddrRules - 1; r >= 0; r--) begin
                    if (dst >= IdWidth'(id_route_map_i[r].start_addr) &&
                        dst <  IdWidth'(id_route_map_i[r].end_addr)) begin
                        rid = RouteSelWidth'(id_route_map_i[r].idx);
                        hit = 1'b1;
                    end
                end
            end
        end else begin : g_src
            assign rid = dst[RouteSelWidth-1:0];
            assign hit = 1'b1;
            always_comb begin
                out_flit = in_flit;
                out_flit.hdr.dst_id = in_flit.hdr.dst_id >> RouteSelWidth;
            end
        end

        assign sel_rid = (state_q == Locked) ? lock_rid_q : rid;
        assign set_mis = hs & (state_q == Locked) & (rid != lock_rid_q);
        assign set_ovl = hs & ~last &
                         (cnt_q == CntWidth'(MaxPktLen - 1));
        assign set_nom = hs & ~hit;

        always_comb begin
            state_d    = state_q;
            lock_rid_d = lock_rid_q;
            unique case (state_q)
                Unlocked: begin
                    if (LockRouting && hs && !last) begin
                        state_d    = Locked;
                        lock_rid_d = rid;
                    end
                end
                Locked: begin
                    if (hs && last) state_d = Unlocked;
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q    <= Unlocked;
                lock_rid_q <= '0;
                cnt_q      <= '0;
                err_q      <= '0;
            end else begin
                state_q    <= state_d;
                lock_rid_q <= lock_rid_d;
                if (hs) begin
                    if (last)
                        cnt_q <= '0;
                    else if (cnt_q != CntWidth'(MaxPktLen))
                        cnt_q <= cnt_q + CntWidth'(1);
                end
                // A new error in the clearing cycle still survives.
                err_q <= {set_nom, set_ovl, set_mis} |
                         (err_q & {3{~clear_err_i}});
            end
        end

        assign err_mismatch_o[c] = err_q[0];
        assign err_overlen_o[c]  = err_q[1];
        assign err_nomatch_o[c]  = err_q[2];

        if (PipeReg) begin : g_pipe
            logic                     full_q;
            flit_t                    flit_q;
            logic [RouteSelWidth-1:0] rid_q;

            assign ready_o[c] = ~full_q | ready_i[c];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    full_q <= 1'b0;
                    flit_q <= '0;
                    rid_q  <= '0;
                end else if (hs) begin
                    full_q <= 1'b1;
                    flit_q <= out_flit;
                    rid_q  <= sel_rid;
                end else if (full_q & ready_i[c]) begin
                    full_q <= 1'b0;
                end
            end

            assign valid_o[c]        = full_q;
            assign channel_o[c]      = flit_q;
            assign route_sel_id_o[c] = full_q ? rid_q : '0;
            assign route_sel_o[c]    = full_q ? (NumRoutes'(1) << rid_q)
                                              : '0;
        end else begin : g_comb
            assign ready_o[c]        = ready_i[c];
            assign valid_o[c]        = valid_i[c];
            assign channel_o[c]      = out_flit;
            assign route_sel_id_o[c] = sel_rid;
            assign route_sel_o[c]    = NumRoutes'(1) << sel_rid;
        end
    end

endmodule

// File: tb/tb_floo_route_select_multi.sv
// Bench for floo_route_select_multi: four configurations share one stimulus
// stream and are checked each cycle against a packet-level reference model.
module tb_floo_route_select_multi;
    import floo_route_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  clr;
    logic [5:0]            xy_id;
    id_rule_t [3:0]        map;
    logic [1:0]            vld;
    logic [1:0]            rdy;
    flit_t [1:0]           ch_i;

    logic [1:0]            v_o   [4];
    logic [1:0]            r_o   [4];
    flit_t [1:0]           ch_o  [4];
    logic [1:0][4:0]       sel_o [4];
    logic [1:0][2:0]       sid_o [4];
    logic [1:0]            e_mis [4];
    logic [1:0]            e_ovl [4];
    logic [1:0]            e_nom [4];

    int n_run  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // k=0 XY comb (MaxPktLen 4), k=1 XY piped, k=2 IdTable, k=3 source
    for (genvar k = 0; k < 4; k++) begin : g_dut
        floo_route_select_multi #(
            .RouteAlgo (route_algo_e'(k == 2 ? 1 : (k == 3 ? 2 : 0))),
            .PipeReg   (k == 1),
            .MaxPktLen (k == 0 ? 4 : 16)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .xy_id_i        (xy_id),
            .id_route_map_i (map),
            .valid_i        (vld),
            .ready_o        (r_o[k]),
            .channel_i      (ch_i),
            .valid_o        (v_o[k]),
            .ready_i        (rdy),
            .channel_o      (ch_o[k]),
            .route_sel_o    (sel_o[k]),
            .route_sel_id_o (sid_o[k]),
            .clear_err_i    (clr),
            .err_mismatch_o (e_mis[k]),
            .err_overlen_o  (e_ovl[k]),
            .err_nomatch_o  (e_nom[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    rs [4];
    int    re [4];
    int    ri [4];
    bit    m_lock [4][2];
    int    m_lrid [4][2];
    int    m_cnt  [4][2];
    bit    m_mis  [4][2];
    bit    m_ovl  [4][2];
    bit    m_nom  [4][2];
    bit    m_full [4][2];
    flit_t m_pf   [4][2];
    int    m_prid [4][2];

    function automatic int max_len(int k);
        return (k == 0) ? 4 : 16;
    endfunction

    // -1 means no table rule matched.
    function automatic int route(int k, int d);
        int x, y, mx, my, res;
        bit found;
        x = d % 8; y = d / 8;
        mx = int'(xy_id) % 8; my = int'(xy_id) / 8;
        res = 0;
        if (k == 3) begin
            res = d % 8;
        end else if (k == 2) begin
            found = 0;
            res = -1;
            for (int i = 0; i < 4; i++)
                if (!found && d >= rs[i] && d < re[i]) begin
                    res = ri[i];
                    found = 1;
                end
        end else begin
            if (x > mx)      res = 4;
            else if (x < mx) res = 2;
            else if (y > my) res = 3;
            else if (y < my) res = 1;
            else             res = 0;
        end
        return res;
    endfunction

    function automatic flit_t fout(int k, flit_t f);
        flit_t o;
        o = f;
        if (k == 3) o.hdr.dst_id = f.hdr.dst_id / 8;
        return o;
    endfunction

    function automatic bit exp_ready(int k, int c);
        return (k == 1) ? (!m_full[k][c] || rdy[c]) : rdy[c];
    endfunction

    function automatic flit_t mkd(int d, bit last, int pay);
        flit_t f;
        f.hdr.dst_id = 6'(d);
        f.hdr.last   = last;
        f.payload    = 8'(pay);
        return f;
    endfunction

    function automatic flit_t mk(int x, int y, bit last, int pay);
        return mkd(y * 8 + x, last, pay);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                flit_t f;
                int r, rr, use_r;
                bit hs, lst;
                f = ch_i[c];
                if (rst) begin
                    m_lock[k][c] = 0; m_lrid[k][c] = 0; m_cnt[k][c] = 0;
                    m_mis[k][c] = 0; m_ovl[k][c] = 0; m_nom[k][c] = 0;
                    m_full[k][c] = 0; m_pf[k][c] = '0; m_prid[k][c] = 0;
                end else begin
                    r = route(k, int'(f.hdr.dst_id));
                    rr = (r < 0) ? 0 : r;
                    lst = f.hdr.last;
                    hs = vld[c] && exp_ready(k, c);
                    use_r = m_lock[k][c] ? m_lrid[k][c] : rr;
                    m_mis[k][c] = (hs && m_lock[k][c] && rr != m_lrid[k][c])
                                  || (m_mis[k][c] && !clr);
                    m_ovl[k][c] = (hs && !lst &&
                                   m_cnt[k][c] == max_len(k) - 1)
                                  || (m_ovl[k][c] && !clr);
                    m_nom[k][c] = (hs && r < 0) || (m_nom[k][c] && !clr);
                    if (k == 1) begin
                        if (hs) begin
                            m_full[k][c] = 1;
                            m_pf[k][c]   = fout(k, f);
                            m_prid[k][c] = use_r;
                        end else if (m_full[k][c] && rdy[c]) begin
                            m_full[k][c] = 0;
                        end
                    end
                    if (hs) begin
                        if (lst) begin
                            m_lock[k][c] = 0;
                            m_cnt[k][c]  = 0;
                        end else begin
                            if (!m_lock[k][c]) begin
                                m_lock[k][c] = 1;
                                m_lrid[k][c] = rr;
                            end
                            if (m_cnt[k][c] < max_len(k))
                                m_cnt[k][c]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(string nm, int k, int c,
                       logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d ch%0d: got %0h want %0h at %0t",
                     nm, k, c, act, exp, $time);
        end
    endtask

    task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                bit ev;
                int er, r;
                logic [4:0] es;
                flit_t ef;
                r = route(k, int'(ch_i[c].hdr.dst_id));
                if (k == 1) begin
                    ev = m_full[k][c];
                    er = ev ? m_prid[k][c] : 0;
                    ef = m_pf[k][c];
                end else begin
                    ev = vld[c];
                    er = m_lock[k][c] ? m_lrid[k][c] : ((r < 0) ? 0 : r);
                    ef = fout(k, ch_i[c]);
                end
                es = (k == 1 && !ev) ? 5'd0 : 5'(1 << er);
                chk("valid_o", k, c, v_o[k][c], ev);
                chk("ready_o", k, c, r_o[k][c], exp_ready(k, c));
                chk("route_sel_id_o", k, c, sid_o[k][c], er);
                chk("route_sel_o", k, c, sel_o[k][c], es);
                chk("err_mismatch_o", k, c, e_mis[k][c], m_mis[k][c]);
                chk("err_overlen_o", k, c, e_ovl[k][c], m_ovl[k][c]);
                chk("err_nomatch_o", k, c, e_nom[k][c], m_nom[k][c]);
                if (ev) chk("channel_o", k, c, ch_o[k][c], ef);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare_all();
    end

    task automatic adv();
        @(posedge clk);
        #1;
        vld = '0;
        clr = 1'b0;
    endtask

    initial begin
        int    xs [5];
        int    ys [5];
        flit_t fl [4];
        xs = '{2, 2, 1, 2, 3};
        ys = '{2, 1, 2, 3, 2};
        rs = '{0, 8, 0, 0};
        re = '{8, 16, 0, 0};
        ri = '{3, 1, 0, 0};
        rst = 1'b1; clr = 1'b0; vld = '0; rdy = 2'b11; ch_i = '0;
        xy_id = {3'd2, 3'd2};
        for (int i = 0; i < 4; i++) begin
            map[i].idx        = 3'(ri[i]);
            map[i].start_addr = 6'(rs[i]);
            map[i].end_addr   = 6'(re[i]);
        end
        adv();
        adv();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        lit("reset_pipe_valid", v_o[1], 2'b00);
        lit("reset_pipe_ready", r_o[1], 2'b11);
        lit("reset_pipe_sel", sel_o[1][0], 5'b00000);
        lit("reset_err_mis", e_mis[0], 2'b00);
        adv();

        // XY: eject, south, west, north, east
        for (int i = 0; i < 5; i++) begin
            ch_i[0] = mk(xs[i], ys[i], 1'b1, i);
            vld[0] = 1'b1;
            @(negedge clk);
            lit("xy_route_id", sid_o[0][0], i);
            lit("xy_onehot", sel_o[0][0], 5'b00001 << i);
            adv();
        end

        // wormhole lock: head East, body/tail aimed West
        ch_i[0] = mk(3, 2, 1'b0, 10); vld[0] = 1'b1;
        @(negedge clk);
        lit("lock_head", sid_o[0][0], 4);
        adv();
        ch_i[0] = mk(0, 0, 1'b0, 11); vld[0] = 1'b1;
        @(negedge clk);
        lit("lock_body", sid_o[0][0], 4);
        lit("lock_mis_early", e_mis[0][0], 0);
        adv();
        ch_i[0] = mk(0, 0, 1'b1, 12); vld[0] = 1'b1;
        @(negedge clk);
        lit("lock_tail", sel_o[0][0], 5'b10000);
        lit("lock_mis_set", e_mis[0][0], 1);
        adv();
        ch_i[0] = mk(0, 0, 1'b1, 13); vld[0] = 1'b1;
        @(negedge clk);
        lit("unlock_west", sid_o[0][0], 2);
        adv();
        clr = 1'b1;
        adv();

        // over-length with clear colliding on the setting handshake
        for (int i = 1; i <= 5; i++) begin
            ch_i[0] = mk(3, 2, i == 5, 20 + i);
            vld[0] = 1'b1;
            clr = (i == 4);
            @(negedge clk);
            if (i == 4) lit("ovl_before", e_ovl[0][0], 0);
            if (i == 5) lit("ovl_set_vs_clear", e_ovl[0][0], 1);
            adv();
        end
        @(negedge clk);
        lit("ovl_sticky", e_ovl[0][0], 1);
        clr = 1'b1;
        adv();
        @(negedge clk);
        lit("ovl_cleared", e_ovl[0][0], 0);
        adv();

        // IdTable
        ch_i[0] = mkd(9, 1'b1, 30); vld[0] = 1'b1;
        @(negedge clk);
        lit("tab_hit_id", sid_o[2][0], 1);
        lit("tab_hit_onehot", sel_o[2][0], 5'b00010);
        lit("tab_nom_clear", e_nom[2][0], 0);
        adv();
        ch_i[0] = mkd(20, 1'b1, 31); vld[0] = 1'b1;
        @(negedge clk);
        lit("tab_miss_id", sid_o[2][0], 0);
        lit("tab_miss_onehot", sel_o[2][0], 5'b00001);
        adv();
        @(negedge clk);
        lit("tab_nomatch", e_nom[2][0], 1);
        adv();

        // source routing
        ch_i[0] = mkd(6'b101011, 1'b1, 32); vld[0] = 1'b1;
        @(negedge clk);
        lit("src_id", sid_o[3][0], 3);
        lit("src_onehot", sel_o[3][0], 5'b01000);
        lit("src_dst_shift", ch_o[3][0].hdr.dst_id, 6'b000101);
        adv();

        // pipe stage backpressure on ch1
        fl[0] = mk(3, 2, 1'b1, 40);
        fl[1] = mk(2, 3, 1'b1, 41);
        fl[2] = mk(1, 2, 1'b1, 42);
        fl[3] = mk(2, 1, 1'b1, 43);
        rdy[1] = 1'b0;
        ch_i[1] = fl[0]; vld[1] = 1'b1;
        @(negedge clk);
        lit("pipe_empty_valid", v_o[1][1], 0);
        lit("pipe_empty_ready", r_o[1][1], 1);
        adv();
        for (int i = 0; i < 3; i++) begin
            ch_i[1] = fl[1]; vld[1] = 1'b1;
            @(negedge clk);
            lit("pipe_hold_valid", v_o[1][1], 1);
            lit("pipe_hold_ready", r_o[1][1], 0);
            lit("pipe_hold_flit", ch_o[1][1], fl[0]);
            lit("pipe_hold_id", sid_o[1][1], 4);
            adv();
        end
        rdy[1] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            ch_i[1] = fl[i]; vld[1] = 1'b1;
            @(negedge clk);
            lit("pipe_stream_flit", ch_o[1][1], fl[i-1]);
            lit("pipe_stream_ready", r_o[1][1], 1);
            adv();
        end
        @(negedge clk);
        lit("pipe_last_flit", ch_o[1][1], fl[3]);
        lit("pipe_last_id", sid_o[1][1], 1);
        adv();
        @(negedge clk);
        lit("pipe_drained", v_o[1][1], 0);
        adv();

        // reset in the middle of a packet
        ch_i[0] = mk(3, 2, 1'b0, 50); vld[0] = 1'b1;
        @(negedge clk);
        lit("rst_head", sid_o[0][0], 4);
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        ch_i[0] = mk(0, 0, 1'b1, 51); vld[0] = 1'b1;
        @(negedge clk);
        lit("rst_fresh_route", sid_o[0][0], 2);
        lit("rst_pipe_valid", v_o[1][0], 0);
        lit("rst_pipe_sel", sel_o[1][0], 5'b00000);
        lit("rst_pipe_ready", r_o[1], 2'b11);
        lit("rst_nom_cleared", e_nom[2][0], 0);
        adv();
        @(negedge clk);
        lit("rst_no_mismatch", e_mis[0][0], 0);
        lit("rst_no_overlen", e_ovl[0][0], 0);
        adv();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout want completion");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/floo_route_select_multi.md
# floo_route_select_multi

Multi-channel route-selection stage for the NoC router input side. It computes the output port for up to `NumChannels` independent input channels (virtual channels or input ports) using XY, ID-table or source routing. It holds a per-channel wormhole lock and can optionally register each decision behind a valid/ready pipeline stage. It also reports sticky protocol errors (route mismatch inside a locked packet, over-length packet, unmatched table lookup) instead of simulation-only warnings.

## Interface
- `NumChannels`, 2: independent channels, each with its own lock, counter and pipe stage.
- `NumRoutes`, 5: output ports; `RouteSelWidth = $clog2(NumRoutes)`.
- `RouteAlgo`, XYRouting: XYRouting, IdTable or SourceRouting; any other value is a `$fatal` at elaboration.
- `IdWidth`, 6: destination ID width. For XY: x = low `IdWidth/2` bits, y = high half. `IdWidth` must be even.
- `NumAddrRules`, 4: IdTable rule count (idx, start_addr inclusive, end_addr exclusive).
- `LockRouting`, 1: enables the wormhole lock.
- `PipeReg`, 0: 1 inserts a one-entry register stage per channel.
- `MaxPktLen`, 16: flits allowed per packet before the over-length error; must be ≥1.
- `flit_t`, logic: must contain `hdr.dst_id[IdWidth-1:0]` and `hdr.last`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `xy_id_i` in `IdWidth`: this router's coordinates.
- `id_route_map_i` in `NumAddrRules` rules: IdTable map.
- `valid_i` in `NumChannels`: input valid.
- `ready_o` out `NumChannels`: input ready.
- `channel_i` in `NumChannels` x flit_t: input flits.
- `valid_o` out `NumChannels`: output valid.
- `ready_i` in `NumChannels`: downstream ready.
- `channel_o` out `NumChannels` x flit_t: output flits; dst_id is shifted when SourceRouting.
- `route_sel_o` out `NumChannels` x `NumRoutes`: one-hot route.
- `route_sel_id_o` out `NumChannels` x `RouteSelWidth`: binary route.
- `clear_err_i` in 1: clears all sticky errors.
- `err_mismatch_o` out `NumChannels`: sticky error flag.
- `err_overlen_o` out `NumChannels`: sticky error flag.
- `err_nomatch_o` out `NumChannels`: sticky error flag.

## Operation
- Routing is combinational per channel and gives `rid`.
- **XY:**
  - x and y equal to `xy_id_i` → 0 (Eject).
  - x equal, y smaller → 1 (South); x equal, y larger → 3 (North).
  - x smaller → 2 (West); x larger → 4 (East).
- **IdTable:** the lowest-indexed matching rule wins. No match → `rid = 0`, and the accepted flit sets `err_nomatch_o`.
- **SourceRouting:** `rid = dst_id[RouteSelWidth-1:0]`; the output flit carries `dst_id >> RouteSelWidth`, zero-filled.
- An input handshake is `valid_i & ready_o`.
- **Lock FSM per channel (`LockRouting=1`):** states UNLOCKED and LOCKED.
  - UNLOCKED, handshake with `last=0` → LOCKED; capture `rid` as `lock_rid`.
  - UNLOCKED, handshake with `last=1` → stay UNLOCKED (single-flit packet).
  - LOCKED, handshake with `last=1` → UNLOCKED.
  - While LOCKED, the route used is `lock_rid`. A handshake whose computed `rid != lock_rid` sets `err_mismatch_o`; the flit still follows `lock_rid`.
- With `LockRouting=0` there is no lock and no mismatch error; `rid` is used directly.
- **Flit counter per channel**, width `$clog2(MaxPktLen+1)`:
  - Cleared on a `last` handshake; otherwise +1 per handshake, saturating.
  - A handshake with `last=0` while count == `MaxPktLen-1` sets `err_overlen_o`.
  - Routing is unaffected; the lock is held until `last`.
- **Errors:** each error is sticky until `clear_err_i`. A set condition in the same cycle as `clear_err_i` wins, so the bit reads 1 next cycle.
- **PipeReg=0:**
  - `valid_o = valid_i`, `ready_o = ready_i`, `channel_o` derived from `channel_i`.
  - Route outputs are combinational from the selected route.
- **PipeReg=1:** one register per channel holding flit, route and valid.
  - `ready_o = ~full | ready_i`.
  - Load on input handshake; drain on `valid_o & ready_i`.
  - Simultaneous drain and load is allowed, giving full throughput.
- Channels are fully independent; there is no arbitration here.

## Timing
- **Latency:** PipeReg=0 is 0 cycles. PipeReg=1 is 1 cycle, input handshake to `valid_o`.
- Lock, counter and error state update on the `clk_i` edge after the handshake.
- **Reset (`rst_i=1` at a clock edge):**
  - All locks go to UNLOCKED and all counters to 0.
  - Errors go to 0; pipe registers are emptied (`valid_o=0`, `route_sel_o=0`, `route_sel_id_o=0`).
  - With PipeReg=1, `ready_o=1` after reset.
  - A reset mid-packet abandons the lock; the next flit is routed as a new head.
- `valid_o` must not drop, and the flit or route must not change, while `valid_o & ~ready_i`.
- `route_sel_o` is always one-hot or zero, and zero only when PipeReg=1 and the stage is empty.

## Test plan
- **XY routing,** `xy_id_i`=x2,y2, single-flit packets to (2,2),(2,1),(1,2),(2,3),(3,2) → `route_sel_id_o` 0,1,2,3,4; one-hot {00001,00010,00100,01000,10000}.
- **Lock:** 3-flit packet on ch0 whose head routes East, body flits with dst_id (0,0) → all three flits route 4. `err_mismatch_o[0]` set after the second flit. LOCKED→UNLOCKED on `last`. A following head to (0,0) routes West.
- **Over-length,** MaxPktLen=4: 5 flits, `last` only on the fifth → `err_overlen_o` set after the 4th handshake. `clear_err_i` in the same cycle as the set → the bit remains 1, then clears on a later pulse.
- **PipeReg=1 backpressure:** ch1 holds `ready_i=0` for 3 cycles with `valid_i=1` → `valid_o` asserted from cycle 1, flit stable, `ready_o=0`. Releasing `ready_i` gives one flit per cycle back-to-back.
- **IdTable and SourceRouting:** IdTable rules {[0,8)→3, [8,16)→1}, dst 9 → route 1; dst 20 → route 0 and `err_nomatch_o`. SourceRouting with dst_id=6'b101011 → route 3 and output dst_id=6'b000101.
- **Reset mid-packet:** `rst_i` asserted after the head of a 4-flit packet → all outputs 0 and ready as specified. The next flit is treated as a head with a fresh route, and no errors are flagged.
